// File: rtl/ddr_rd_pkg.sv
// rtl/ddr_rd_pkg.sv - state encoding and default geometry for the DDR multi-burst read engine
package ddr_rd_pkg;

  localparam int DEF_MEM_DQ_WIDTH    = 16;
  localparam int DEF_BURST_LENGTH    = 8;
  localparam int DEF_CTRL_ADDR_WIDTH = 28;
  localparam int DEF_LEN_WIDTH       = 4;
  localparam int DEF_ARLEN           = 15;
  localparam int DEF_ADDR_STEP       = 128;
  localparam int DEF_NB_WIDTH        = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_RD   = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } rd_state_e;

endpackage

// File: rtl/ddr_rd_out_reg.sv
// rtl/ddr_rd_out_reg.sv - one-entry output register that generates the upstream ready
module ddr_rd_out_reg #(
  parameter int WIDTH = 128
) (
  input  logic             i_axi_aclk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  logic push;

  // Ready while empty or being drained this cycle, so a held-high consumer sees no bubbles.
  assign o_in_ready = i_en && (!o_out_valid || i_out_ready);
  assign push       = i_in_valid && o_in_ready;

  always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
    end else if (push) begin
      o_out_valid <= 1'b1;
      o_out_data  <= i_in_data;
    end else if (o_out_valid && i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_rd_burst_dma.sv
// rtl/ddr_rd_burst_dma.sv - command-driven multi-burst AXI4 read engine with rlast framing check
module ddr_rd_burst_dma
  import ddr_rd_pkg::*;
#(
  parameter int MEM_DQ_WIDTH    = DEF_MEM_DQ_WIDTH,
  parameter int BURST_LENGTH    = DEF_BURST_LENGTH,
  parameter int CTRL_ADDR_WIDTH = DEF_CTRL_ADDR_WIDTH,
  parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter int ARLEN           = DEF_ARLEN,
  parameter int ADDR_STEP       = DEF_ADDR_STEP,
  parameter int NB_WIDTH        = DEF_NB_WIDTH
) (
  input  logic                                 i_axi_aclk,
  input  logic                                 i_rstn,
  output logic [CTRL_ADDR_WIDTH-1:0]           o_axi_araddr,
  output logic [LEN_WIDTH-1:0]                 o_axi_arlen,
  output logic                                 o_axi_arvalid,
  input  logic                                 i_axi_arready,
  input  logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0] i_axi_rdata,
  input  logic                                 i_axi_rvalid,
  input  logic                                 i_axi_rlast,
  output logic                                 o_axi_rready,
  input  logic                                 i_cmd_valid,
  output logic                                 o_cmd_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0]           i_cmd_addr,
  input  logic [NB_WIDTH-1:0]                  i_cmd_nburst,
  output logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0] o_rd_data,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err
);

  localparam int BEAT_WIDTH = MEM_DQ_WIDTH * BURST_LENGTH;
  // One spare bit so an overlong burst cannot alias back onto the last-beat index.
  localparam int CNT_WIDTH  = LEN_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]       LAST_BEAT = CNT_WIDTH'(ARLEN);
  localparam logic [CTRL_ADDR_WIDTH-1:0] STEP      = CTRL_ADDR_WIDTH'(ADDR_STEP);

  rd_state_e                state_q, state_d;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q;
  logic [NB_WIDTH-1:0]        remaining_q;
  logic [CNT_WIDTH-1:0]       beat_cnt_q;
  logic                       err_q;
  logic                       rd_en;
  logic                       cmd_fire;
  logic                       beat_fire;

  assign cmd_fire     = i_cmd_valid && o_cmd_ready;
  assign beat_fire    = i_axi_rvalid && o_axi_rready;
  assign o_axi_araddr = addr_q;
  assign o_axi_arlen  = LEN_WIDTH'(ARLEN);
  assign o_err        = err_q;

  always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_fire) state_d = (i_cmd_nburst == '0) ? ST_DONE : ST_AR;
      ST_AR:   if (i_axi_arready) state_d = ST_RD;
      ST_RD:   if (beat_fire && i_axi_rlast) state_d = ST_NEXT;
      ST_NEXT: state_d = (remaining_q <= NB_WIDTH'(1)) ? ST_DONE : ST_AR;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready   = 1'b0;
    o_axi_arvalid = 1'b0;
    o_busy        = 1'b1;
    o_done        = 1'b0;
    rd_en         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
      end
      ST_AR:   o_axi_arvalid = 1'b1;
      ST_RD:   rd_en = 1'b1;
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            addr_q      <= i_cmd_addr;
            remaining_q <= i_cmd_nburst;
            err_q       <= 1'b0;
          end
        end
        ST_AR: begin
          if (i_axi_arready) beat_cnt_q <= '0;
        end
        ST_RD: begin
          if (beat_fire) begin
            if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 1'b1;
            // Early rlast and missing rlast both reduce to rlast disagreeing with the last index.
            if (i_axi_rlast != (beat_cnt_q == LAST_BEAT)) err_q <= 1'b1;
          end
        end
        ST_NEXT: begin
          remaining_q <= remaining_q - 1'b1;
          addr_q      <= addr_q + STEP;
        end
        default: ;
      endcase
    end
  end

  ddr_rd_out_reg #(
    .WIDTH(BEAT_WIDTH)
  ) u_out_reg (
    .i_axi_aclk (i_axi_aclk),
    .i_rstn     (i_rstn),
    .i_en       (rd_en),
    .i_in_valid (i_axi_rvalid),
    .i_in_data  (i_axi_rdata),
    .o_in_ready (o_axi_rready),
    .o_out_data (o_rd_data),
    .o_out_valid(o_rd_valid),
    .i_out_ready(i_rd_ready)
  );

endmodule
